// File: rtl/pool_out_writer.sv
// Pooling output sink: writes each accepted row to BRAM at base + k*stride, raises done after num_rows.
// Write latency 1 cycle; no backpressure, rows outside RUN are dropped and flagged.
module pool_out_writer #(
  parameter int DWIDTH       = 8,
  parameter int MAT_MUL_SIZE = 4,
  parameter int AWIDTH       = 10,
  parameter int MASK_WIDTH   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [AWIDTH-1:0]              base_addr,
  input  logic [AWIDTH-1:0]              num_rows,
  input  logic [AWIDTH-1:0]              addr_stride,
  input  logic                           in_data_available,
  input  logic [MAT_MUL_SIZE*DWIDTH-1:0] inp_data,
  input  logic [MASK_WIDTH-1:0]          validity_mask,
  output logic [AWIDTH-1:0]              bram_addr,
  output logic [MAT_MUL_SIZE*DWIDTH-1:0] bram_wdata,
  output logic [MAT_MUL_SIZE-1:0]        bram_we,
  output logic                           busy,
  output logic                           done,
  output logic                           err_unexpected
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [AWIDTH-1:0] cur_addr;
  logic [AWIDTH-1:0] rows_tgt;
  logic [AWIDTH-1:0] stride;
  logic [AWIDTH-1:0] row_cnt;
  logic [AWIDTH-1:0] row_cnt_nxt;

  assign row_cnt_nxt = row_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      cur_addr       <= '0;
      rows_tgt       <= '0;
      stride         <= '0;
      row_cnt        <= '0;
      bram_addr      <= '0;
      bram_wdata     <= '0;
      bram_we        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      bram_we <= '0;
      case (state)
        IDLE, DONE: begin
          if (in_data_available)
            err_unexpected <= 1'b1;
          // A start in the same cycle as a stray row wins: the flag ends up cleared.
          if (start) begin
            cur_addr       <= base_addr;
            rows_tgt       <= num_rows;
            stride         <= addr_stride;
            row_cnt        <= '0;
            err_unexpected <= 1'b0;
            if (num_rows != '0) begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (in_data_available) begin
            bram_addr  <= cur_addr;
            bram_wdata <= inp_data;
            bram_we    <= validity_mask;
            cur_addr   <= cur_addr + stride;
            row_cnt    <= row_cnt_nxt;
            if (row_cnt_nxt == rows_tgt) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_out_writer.sv
// Directed and randomized bench for pool_out_writer against a row-index based reference model.
module tb_pool_out_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  num_rows;
  logic [9:0]  addr_stride;
  logic        in_data_available;
  logic [31:0] inp_data;
  logic [3:0]  validity_mask;
  logic [9:0]  bram_addr;
  logic [31:0] bram_wdata;
  logic [3:0]  bram_we;
  logic        busy;
  logic        done;
  logic        err_unexpected;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: expected row k lands at (base + k*stride) mod 1024.
  bit          m_run;
  int          m_base, m_stride, m_rows, m_cnt;
  logic [9:0]  e_addr;
  logic [31:0] e_wdata;
  logic [3:0]  e_we;
  logic        e_busy, e_done, e_err;

  pool_out_writer dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_rows(num_rows), .addr_stride(addr_stride),
    .in_data_available(in_data_available), .inp_data(inp_data),
    .validity_mask(validity_mask), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_we(bram_we), .busy(busy), .done(done),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".addr"},  32'(bram_addr),      32'(e_addr));
    check({tag, ".wdata"}, bram_wdata,          e_wdata);
    check({tag, ".we"},    32'(bram_we),        32'(e_we));
    check({tag, ".busy"},  32'(busy),           32'(e_busy));
    check({tag, ".done"},  32'(done),           32'(e_done));
    check({tag, ".err"},   32'(err_unexpected), 32'(e_err));
  endtask

  task automatic model_reset();
    m_run = 0; m_base = 0; m_stride = 0; m_rows = 0; m_cnt = 0;
    e_addr = '0; e_wdata = '0; e_we = '0; e_busy = 0; e_done = 0; e_err = 0;
  endtask

  task automatic model_edge();
    e_we = '0;
    if (!m_run) begin
      if (in_data_available) e_err = 1;
      if (start) begin
        m_base = int'(base_addr); m_stride = int'(addr_stride);
        m_rows = int'(num_rows);  m_cnt = 0;
        e_err  = 0;
        m_run  = (m_rows != 0);
        e_done = (m_rows == 0);
      end
    end else if (in_data_available) begin
      e_addr  = 10'((m_base + m_cnt * m_stride) % 1024);
      e_wdata = inp_data;
      e_we    = validity_mask;
      m_cnt++;
      if (m_cnt == m_rows) begin
        m_run  = 0;
        e_done = 1;
      end
    end
    e_busy = m_run;
  endtask

  // Apply one cycle of inputs, advance through the edge, then compare away from it.
  task automatic step(input string tag, input logic st, input logic [9:0] b, input logic [9:0] n,
                      input logic [9:0] s, input logic dav, input logic [3:0] mask);
    start = st; base_addr = b; num_rows = n; addr_stride = s;
    in_data_available = dav; validity_mask = mask; inp_data = $urandom;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 10'h0, 10'h0, 10'h0, 1'b0, 4'h0);
  endtask

  initial begin
    reset = 1'b1; start = 0; base_addr = 0; num_rows = 0; addr_stride = 0;
    in_data_available = 0; inp_data = 0; validity_mask = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;
    idle("post_reset");

    // Basic run: four back-to-back full rows from 0x10.
    step("basic_start", 1, 10'h010, 10'd4, 10'd1, 0, 4'h0);
    for (int i = 0; i < 4; i++) begin
      step("basic_row", 0, 10'h0, 10'h0, 10'h0, 1, 4'hF);
      check("basic_addr_const", 32'(bram_addr), 32'h10 + 32'(i));
    end
    check("basic_done_const", 32'(done), 32'd1);
    idle("basic_hold");

    // Stride with address wrap.
    step("wrap_start", 1, 10'h3FE, 10'd3, 10'd3, 0, 4'h0);
    step("wrap_r0", 0, 10'h0, 10'h0, 10'h0, 1, 4'hF);
    check("wrap_a0", 32'(bram_addr), 32'h3FE);
    step("wrap_r1", 0, 10'h0, 10'h0, 10'h0, 1, 4'hF);
    check("wrap_a1", 32'(bram_addr), 32'h001);
    step("wrap_r2", 0, 10'h0, 10'h0, 10'h0, 1, 4'hF);
    check("wrap_a2", 32'(bram_addr), 32'h004);

    // Gapped rows with partial and empty masks.
    step("gap_start", 1, 10'($urandom), 10'd3, 10'($urandom_range(1, 9)), 0, 4'h0);
    step("gap_r0", 0, 10'h0, 10'h0, 10'h0, 1, 4'h5);
    idle("gap_idle1");
    idle("gap_idle2");
    step("gap_r1", 0, 10'h0, 10'h0, 10'h0, 1, 4'h0);
    step("gap_r2", 0, 10'h0, 10'h0, 10'h0, 1, 4'h8);
    idle("gap_hold");

    // Zero-row run, then a stray row while DONE.
    step("zero_start", 1, 10'h123, 10'd0, 10'd1, 0, 4'h0);
    idle("zero_hold");
    step("zero_stray", 0, 10'h0, 10'h0, 10'h0, 1, 4'hF);
    check("zero_err_const", 32'(err_unexpected), 32'd1);

    // Start with a simultaneous stray row, then a start mid-run that must be ignored.
    step("mid_start", 1, 10'h100, 10'd4, 10'd2, 1, 4'h0);
    step("mid_r0", 0, 10'h0, 10'h0, 10'h0, 1, 4'hF);
    step("mid_r1", 0, 10'h0, 10'h0, 10'h0, 1, 4'h3);
    step("mid_restart", 1, 10'h200, 10'd9, 10'd7, 1, 4'hC);
    check("mid_addr_const", 32'(bram_addr), 32'h104);
    step("mid_r3", 0, 10'h0, 10'h0, 10'h0, 1, 4'hF);
    idle("mid_hold");

    // Asynchronous reset after two of four rows.
    step("ar_start", 1, 10'h040, 10'd4, 10'd1, 0, 4'h0);
    step("ar_r0", 0, 10'h0, 10'h0, 10'h0, 1, 4'hF);
    step("ar_r1", 0, 10'h0, 10'h0, 10'h0, 1, 4'hF);
    in_data_available = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("ar_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("ar2_start", 1, 10'h2F0, 10'd4, 10'd5, 0, 4'h0);
    for (int i = 0; i < 4; i++)
      step("ar2_row", 0, 10'h0, 10'h0, 10'h0, 1, 4'($urandom));
    idle("ar2_hold");

    // Randomized traffic: occasional starts, bursty rows, random masks.
    for (int i = 0; i < 300; i++)
      step("rand", ($urandom_range(0, 9) == 0), 10'($urandom), 10'($urandom_range(0, 6)),
           10'($urandom), ($urandom_range(0, 3) != 0), 4'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
